trace_capture_buffer: RTL and testbench

Synthesizable, parametrised on-chip execution tracer for the cpu. It records pc, register-write and memory-access events into a circular buffer, logic-analyser style. Capture can stop on buffer full, on a pc trigger plus a post-trigger count, or on a cycle limit. The buffer is then drained oldest-first over a valid/ready stream, replacing ad-hoc $monitor/$display probing in benches and on FPGA.

---
 rtl/trace_pkg.sv | 53 +++++
 rtl/trace_ring_mem.sv | 64 ++++++
 rtl/trace_capture_buffer.sv | 174 +++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the execution tracer: FSM encoding, event flag
// bit positions and the layout of one captured trace entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Bit positions inside the 3-bit flags field of an entry.
    localparam int FLAG_REG_WE = 0;
    localparam int FLAG_MEM_WE = 1;
    localparam int FLAG_MEM_RE = 2;
    localparam int FLAGS_W     = 3;
    localparam int REG_ADDR_W  = 5;

    // Entry layout, LSB first:
    // mem_data | mem_addr | reg_wdata | reg_waddr | pc | flags | stamp
    function automatic int entry_w(input int stamp_w, input int xlen);
        return stamp_w + FLAGS_W + REG_ADDR_W + 4 * xlen;
    endfunction

    function automatic int off_mem_data(input int xlen);
        return 0 * xlen;
    endfunction

    function automatic int off_mem_addr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_reg_wdata(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int off_reg_waddr(input int xlen);
        return 3 * xlen;
    endfunction

    function automatic int off_pc(input int xlen);
        return 3 * xlen + REG_ADDR_W;
    endfunction

    function automatic int off_flags(input int xlen);
        return 4 * xlen + REG_ADDR_W;
    endfunction

    function automatic int off_stamp(input int xlen);
        return 4 * xlen + REG_ADDR_W + FLAGS_W;
    endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// Circular entry store for the tracer. Holds DEPTH entries with write and
// read pointers plus an occupancy count. 'push' appends into free space,
// 'overwrite' appends over the oldest entry when full (read pointer moves
// with it), 'pop' retires the oldest entry. The caller never asserts pop in
// the same cycle as push/overwrite, since readout and capture are exclusive.
module trace_ring_mem
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 152,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               overwrite,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic [AW:0]        count,
    output logic               full
);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = storage[rd_ptr];

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (!clear && (push || overwrite)) begin
            storage[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push || overwrite) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (overwrite || pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                count <= count + 1'b1;
            end else if (pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// On-chip execution tracer. Records pc / register-write / memory events into
// a ring buffer after 'arm', stops on full (no-wrap), trigger plus post
// count, or cycle limit, then drains oldest-first over a valid/ready port.
//
// state | meaning
// IDLE  | after reset, events ignored
// ARMED | capturing, watching for the pc trigger
// POST  | trigger seen, capturing POST_COUNT more entries
// DONE  | capture stopped, buffer drains over out_valid/out_ready
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int STAMP_W     = 16,
    parameter int POST_COUNT  = 4,
    parameter int CYCLE_LIMIT = 0,
    localparam int ENTRY_W    = entry_w(STAMP_W, XLEN),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               wrap_mode,
    input  logic               trig_en,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic [XLEN-1:0]    pc,
    input  logic               reg_we,
    input  logic [4:0]         reg_waddr,
    input  logic [XLEN-1:0]    reg_wdata,
    input  logic               mem_we,
    input  logic               mem_re,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic [XLEN-1:0]    mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_entry,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    localparam int PCNT_W = (POST_COUNT < 1) ? 1 : $clog2(POST_COUNT + 1);
    // Last stamp value allowed when a cycle limit is configured.
    localparam logic [STAMP_W-1:0] LIMIT_STAMP =
        STAMP_W'((CYCLE_LIMIT > 0) ? (CYCLE_LIMIT - 1) : 0);

    trace_state_t        state_q;
    trace_state_t        state_d;
    logic                wrap_q;
    logic [STAMP_W-1:0]  stamp_q;
    logic [PCNT_W-1:0]   post_q;
    logic [PCNT_W-1:0]   post_d;
    logic                overflow_q;

    logic [FLAGS_W-1:0]  flags;
    logic                event_hit;
    logic                capturing;
    logic                full;
    logic                do_push;
    logic                do_over;
    logic                do_drop;
    logic                captured;
    logic                trig_hit;
    logic                limit_hit;
    logic                pop;
    logic [ENTRY_W-1:0]  wr_entry;
    logic [ENTRY_W-1:0]  rd_entry;

    // Event classification; x0 writes are architecturally invisible, so skip them.
    always_comb begin
        flags              = '0;
        flags[FLAG_REG_WE] = reg_we && (reg_waddr != 5'd0);
        flags[FLAG_MEM_WE] = mem_we;
        flags[FLAG_MEM_RE] = mem_re;
    end

    assign event_hit = |flags;
    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign do_push   = capturing && event_hit && !full && !arm;
    assign do_over   = capturing && event_hit && full && wrap_q && !arm;
    assign do_drop   = capturing && event_hit && full && !wrap_q;
    assign captured  = do_push || do_over;
    assign trig_hit  = (state_q == ST_ARMED) && trig_en && (pc == trig_pc);
    assign limit_hit = (CYCLE_LIMIT != 0) && capturing && (stamp_q == LIMIT_STAMP);

    assign wr_entry  = {stamp_q, flags, pc, reg_waddr, reg_wdata, mem_addr, mem_data};

    assign out_valid = (state_q == ST_DONE) && (count != '0);
    assign out_entry = out_valid ? rd_entry : '0;
    assign pop       = out_valid && out_ready && !arm;
    assign state     = state_q;
    assign overflow  = overflow_q;

    trace_ring_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ring (
        .clock     (clock),
        .reset     (reset),
        .clear     (arm),
        .push      (do_push),
        .overwrite (do_over),
        .pop       (pop),
        .wdata     (wr_entry),
        .rdata     (rd_entry),
        .count     (count),
        .full      (full)
    );

    // FSM state and post-trigger counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    // Next-state logic; stop causes override the trigger, arm overrides all.
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        case (state_q)
            ST_ARMED: begin
                if (trig_hit) begin
                    post_d  = PCNT_W'(POST_COUNT);
                    state_d = (POST_COUNT == 0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (captured && (post_q != '0)) begin
                    post_d = post_q - 1'b1;
                    if (post_q == PCNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (do_drop || limit_hit) begin
            state_d = ST_DONE;
        end
        if (arm) begin
            state_d = ST_ARMED;
            post_d  = '0;
        end
    end

    // Wrap-mode latch, cycle stamp and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
        end else if (arm) begin
            wrap_q     <= wrap_mode;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (capturing) begin
                stamp_q <= stamp_q + 1'b1;
            end
            if (do_over || do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer using three parameterisations:
// a: DEPTH=4 no limit, b: DEPTH=4 CYCLE_LIMIT=10, c: DEPTH=8 POST_COUNT=2.
module tb_trace_capture_buffer;

    localparam int XLEN    = 32;
    localparam int STAMP_W = 16;
    localparam int ENTRY_W = STAMP_W + 8 + 4 * XLEN;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic            wrap_mode;
    logic            trig_en;
    logic [XLEN-1:0] trig_pc;
    logic [XLEN-1:0] pc;
    logic            reg_we;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic            mem_we;
    logic            mem_re;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;

    logic               arm_a, arm_b, arm_c;
    logic               rdy_a, rdy_b, rdy_c;
    logic               vld_a, vld_b, vld_c;
    logic [ENTRY_W-1:0] ent_a, ent_b, ent_c;
    logic [1:0]         st_a, st_b, st_c;
    logic [2:0]         cnt_a, cnt_b;
    logic [3:0]         cnt_c;
    logic               ovf_a, ovf_b, ovf_c;

    int n_checks = 0;
    int n_fail   = 0;

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(4), .STAMP_W(STAMP_W), .POST_COUNT(4), .CYCLE_LIMIT(0)) dut_a (
        .clock(clock), .reset(reset), .arm(arm_a), .wrap_mode(wrap_mode), .trig_en(trig_en),
        .trig_pc(trig_pc), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(vld_a), .out_ready(rdy_a), .out_entry(ent_a), .state(st_a), .count(cnt_a),
        .overflow(ovf_a));

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(4), .STAMP_W(STAMP_W), .POST_COUNT(4), .CYCLE_LIMIT(10)) dut_b (
        .clock(clock), .reset(reset), .arm(arm_b), .wrap_mode(wrap_mode), .trig_en(trig_en),
        .trig_pc(trig_pc), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(vld_b), .out_ready(rdy_b), .out_entry(ent_b), .state(st_b), .count(cnt_b),
        .overflow(ovf_b));

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(8), .STAMP_W(STAMP_W), .POST_COUNT(2), .CYCLE_LIMIT(0)) dut_c (
        .clock(clock), .reset(reset), .arm(arm_c), .wrap_mode(wrap_mode), .trig_en(trig_en),
        .trig_pc(trig_pc), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(vld_c), .out_ready(rdy_c), .out_entry(ent_c), .state(st_c), .count(cnt_c),
        .overflow(ovf_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] f_stamp(input logic [ENTRY_W-1:0] e);
        return 64'(e[ENTRY_W-1 -: STAMP_W]);
    endfunction
    function automatic logic [63:0] f_flags(input logic [ENTRY_W-1:0] e);
        return 64'(e[4*XLEN+5 +: 3]);
    endfunction
    function automatic logic [63:0] f_pc(input logic [ENTRY_W-1:0] e);
        return 64'(e[3*XLEN+5 +: XLEN]);
    endfunction
    function automatic logic [63:0] f_waddr(input logic [ENTRY_W-1:0] e);
        return 64'(e[3*XLEN +: 5]);
    endfunction
    function automatic logic [63:0] f_wdata(input logic [ENTRY_W-1:0] e);
        return 64'(e[2*XLEN +: XLEN]);
    endfunction
    function automatic logic [63:0] f_maddr(input logic [ENTRY_W-1:0] e);
        return 64'(e[XLEN +: XLEN]);
    endfunction
    function automatic logic [63:0] f_mdata(input logic [ENTRY_W-1:0] e);
        return 64'(e[0 +: XLEN]);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        reg_we    = 1'b0;
        reg_waddr = 5'd0;
        reg_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
    endtask

    initial begin
        reset     = 1'b1;
        wrap_mode = 1'b0;
        trig_en   = 1'b0;
        trig_pc   = '0;
        pc        = '0;
        arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        quiet();
        repeat (2) @(posedge clock);
        #1;
        check("rst_state",  64'(st_a),  64'd0);
        check("rst_count",  64'(cnt_a), 64'd0);
        check("rst_ovf",    64'(ovf_a), 64'd0);
        check("rst_valid",  64'(vld_a), 64'd0);
        check("rst_entry0", 64'(|ent_a), 64'd0);
        reset = 1'b0;
        step();

        // No-wrap full: 6 stores, 4 kept, 5th dropped -> DONE.
        wrap_mode = 1'b0;
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        check("a_armed", 64'(st_a), 64'd1);
        for (int i = 0; i < 6; i++) begin
            pc       = 32'(4 * i);
            mem_we   = 1'b1;
            mem_addr = 32'(32'h100 + i);
            mem_data = 32'(32'hA0 + i);
            step();
        end
        quiet();
        check("a_done",  64'(st_a),  64'd3);
        check("a_count", 64'(cnt_a), 64'd4);
        check("a_ovf",   64'(ovf_a), 64'd1);
        rdy_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("a_vld",   64'(vld_a),       64'd1);
            check("a_pc",    f_pc(ent_a),      64'(4 * k));
            check("a_stamp", f_stamp(ent_a),   64'(k));
            check("a_flags", f_flags(ent_a),   64'd2);
            check("a_maddr", f_maddr(ent_a),   64'(32'h100 + k));
            check("a_mdata", f_mdata(ent_a),   64'(32'hA0 + k));
            step();
        end
        rdy_a = 1'b0;
        check("a_drained",  64'(cnt_a),  64'd0);
        check("a_vld_end",  64'(vld_a),  64'd0);
        check("a_ent_zero", 64'(|ent_a), 64'd0);

        // Wrap mode with cycle limit 10: reg write to x5 every cycle.
        wrap_mode = 1'b1;
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        wrap_mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pc        = 32'(32'h200 + 4 * i);
            reg_we    = 1'b1;
            reg_waddr = 5'd5;
            reg_wdata = 32'(32'h500 + i);
            step();
            if (i == 4) begin
                check("b_full_cnt", 64'(cnt_b), 64'd4);
                check("b_ovf_early", 64'(ovf_b), 64'd1);
            end
            if (i == 8) check("b_still_armed", 64'(st_b), 64'd1);
            if (i == 9) check("b_done_at_limit", 64'(st_b), 64'd3);
        end
        quiet();
        check("b_count", 64'(cnt_b), 64'd4);
        check("b_ovf",   64'(ovf_b), 64'd1);
        rdy_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("b_stamp", f_stamp(ent_b), 64'(6 + k));
            check("b_pc",    f_pc(ent_b),    64'(32'h200 + 4 * (6 + k)));
            check("b_wdata", f_wdata(ent_b), 64'(32'h506 + k));
            check("b_waddr", f_waddr(ent_b), 64'd5);
            check("b_flags", f_flags(ent_b), 64'd1);
            step();
        end
        rdy_b = 1'b0;
        check("b_drained", 64'(cnt_b), 64'd0);

        // Trigger at pc 0x10 with 2 post entries; x0 writes are not events.
        trig_en = 1'b1;
        trig_pc = 32'h10;
        arm_c = 1'b1;
        step();
        arm_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc        = 32'h80;
            reg_we    = 1'b1;
            reg_waddr = 5'd0;
            reg_wdata = 32'hDEAD;
            step();
        end
        quiet();
        check("c_x0_ignored", 64'(cnt_c), 64'd0);
        for (int i = 0; i < 10; i++) begin
            pc       = 32'(4 * i);
            mem_re   = 1'b1;
            mem_addr = 32'(32'h300 + i);
            mem_data = 32'(32'hC0 + i);
            step();
            if (i == 4) check("c_post",      64'(st_c), 64'd2);
            if (i == 5) check("c_post_hold", 64'(st_c), 64'd2);
            if (i == 6) check("c_done",      64'(st_c), 64'd3);
        end
        quiet();
        check("c_count", 64'(cnt_c), 64'd7);
        check("c_ovf",   64'(ovf_c), 64'd0);
        for (int j = 0; j < 7; j++) begin
            rdy_c = 1'b1;
            check("c_vld",   64'(vld_c),     64'd1);
            check("c_pc",    f_pc(ent_c),    64'(4 * j));
            check("c_stamp", f_stamp(ent_c), 64'(3 + j));
            check("c_flags", f_flags(ent_c), 64'd4);
            check("c_mdata", f_mdata(ent_c), 64'(32'hC0 + j));
            step();
            rdy_c = 1'b0;
            check("c_cnt_hold", 64'(cnt_c), 64'(6 - j));
            step();
        end
        check("c_vld_end",  64'(vld_c),  64'd0);
        check("c_ent_zero", 64'(|ent_c), 64'd0);
        trig_en = 1'b0;

        // Re-arm while in DONE after a partial drain.
        wrap_mode = 1'b0;
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc       = 32'(32'h40 + 4 * i);
            mem_we   = 1'b1;
            mem_data = 32'(i);
            step();
        end
        quiet();
        check("d_done",  64'(st_a),  64'd3);
        check("d_count", 64'(cnt_a), 64'd4);
        rdy_a = 1'b1;
        step();
        step();
        rdy_a = 1'b0;
        check("d_partial_cnt", 64'(cnt_a),     64'd2);
        check("d_partial_pc",  f_pc(ent_a),    64'h48);
        arm_a    = 1'b1;
        mem_we   = 1'b1;
        pc       = 32'h500;
        mem_data = 32'h55;
        step();
        arm_a = 1'b0;
        check("d_rearm_state", 64'(st_a),  64'd1);
        check("d_rearm_count", 64'(cnt_a), 64'd0);
        check("d_rearm_ovf",   64'(ovf_a), 64'd0);
        check("d_rearm_vld",   64'(vld_a), 64'd0);
        for (int i = 0; i < 5; i++) begin
            pc = 32'(32'h600 + 4 * i);
            step();
        end
        quiet();
        check("d_second_done", 64'(st_a),        64'd3);
        check("d_stamp0",      f_stamp(ent_a),   64'd0);
        check("d_first_pc",    f_pc(ent_a),      64'h600);

        // Asynchronous reset in the middle of a capture.
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc        = 32'(32'h700 + 4 * i);
            reg_we    = 1'b1;
            reg_waddr = 5'd7;
            reg_wdata = 32'(i);
            step();
        end
        quiet();
        check("e_pre_cnt",   64'(cnt_a), 64'd3);
        check("e_pre_state", 64'(st_a),  64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("e_async_state", 64'(st_a),  64'd0);
        check("e_async_count", 64'(cnt_a), 64'd0);
        check("e_async_ovf",   64'(ovf_a), 64'd0);
        check("e_async_vld",   64'(vld_a), 64'd0);
        #1;
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
